// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel registered mux/arbiter.
// Slice helper works on a widened bus so one function serves every width.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int MAX_CH  = 32;
  localparam int MAX_W   = 256;
  localparam int MAX_BUS = MAX_CH * MAX_W;

  // Callers zero-extend their bus to MAX_BUS and truncate the result to W.
  function automatic logic [MAX_W-1:0] ch_slice(
    input logic [MAX_BUS-1:0] bus,
    input int                 k,
    input int                 w
  );
    logic [MAX_BUS-1:0] shifted;
    shifted = bus >> (k * w);
    return shifted[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr, wrapping.
// The pointer register is owned by the parent.
module rr_arbiter #(
  parameter int N_CH = 8,
  parameter int SW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [N_CH-1:0] gnt,
  output logic [SW-1:0]   idx,
  output logic            any
);

  int          c;
  logic [SW-1:0] ci;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    ci  = '0;
    for (int i = 0; i < N_CH; i++) begin
      c  = (int'(ptr) + i) % N_CH;
      ci = SW'(c);
      if (!any && req[ci]) begin
        any     = 1'b1;
        idx     = ci;
        gnt[ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel registered mux with valid/ready per channel and a
// fixed-select or round-robin grant feeding one output register.
module mux_arb_n
  import mux_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int W    = 8,
  parameter int SW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  output logic [W-1:0]      out_data,
  output logic [SW-1:0]     out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [SW-1:0]   rr_ptr;
  logic [N_CH-1:0] rr_gnt;
  logic [SW-1:0]   rr_idx;
  logic            rr_any;

  logic [N_CH-1:0] fix_gnt;
  logic            fix_hit;

  logic [N_CH-1:0] g_vec;
  logic [SW-1:0]   g_idx;
  logic            g_any;

  logic            can_load;
  logic            xfer;
  logic [W-1:0]    g_word;
  logic [SW-1:0]   ptr_next;

  rr_arbiter #(
    .N_CH (N_CH),
    .SW   (SW)
  ) u_arb (
    .req (in_valid),
    .ptr (rr_ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  // sel may exceed N_CH-1 when N_CH is not a power of two
  always_comb begin
    fix_hit = 1'b0;
    fix_gnt = '0;
    if (int'(sel) < N_CH) begin
      fix_hit      = in_valid[sel];
      fix_gnt[sel] = in_valid[sel];
    end
  end

  always_comb begin
    g_vec = '0;
    g_idx = '0;
    g_any = 1'b0;
    unique case (mode)
      MODE_FIXED: begin
        g_vec = fix_gnt;
        g_idx = sel;
        g_any = fix_hit;
      end
      MODE_RR: begin
        g_vec = rr_gnt;
        g_idx = rr_idx;
        g_any = rr_any;
      end
    endcase
  end

  assign can_load = !out_valid || out_ready;
  assign xfer     = g_any && can_load;
  assign in_ready = can_load ? g_vec : '0;

  assign g_word = W'(ch_slice(MAX_BUS'(in_data), int'(g_idx), W));

  assign ptr_next = (int'(g_idx) == N_CH - 1) ? '0 : g_idx + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_data  <= g_word;
        out_ch    <= g_idx;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer && mode == MODE_RR)
        rr_ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: fixed select, round-robin order and skip,
// back-pressure, invalid select and asynchronous reset.
module tb_mux_arb_n;

  localparam int N_CH = 8;
  localparam int W    = 8;
  localparam int SW   = 3;

  logic              clk;
  logic              rst_n;
  logic              mode;
  logic [SW-1:0]     sel;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_ready;
  logic [W-1:0]      out_data;
  logic [SW-1:0]     out_ch;
  logic              out_valid;
  logic              out_ready;

  int pass_cnt;
  int total_cnt;

  mux_arb_n #(
    .N_CH (N_CH),
    .W    (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int k = 0; k < N_CH; k++)
      in_data[k*W +: W] = 8'(160 + k);
    #12;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 8'h00) $display("FAIL reset_data got %h want 00", out_data);
    else pass_cnt++;
    total_cnt++;
    if (out_ch !== 3'd0) $display("FAIL reset_ch got %0d want 0", out_ch);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 8'h00) $display("FAIL reset_ready got %b want 0", in_ready);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed();
    mode      = 1'b0;
    sel       = 3'd5;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 8'b0010_0000)
      $display("FAIL fixed_ready got %b want 00100000", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_data !== 8'hA5) $display("FAIL fixed_data got %h want a5", out_data);
    else pass_cnt++;
    total_cnt++;
    if (out_ch !== 3'd5) $display("FAIL fixed_ch got %0d want 5", out_ch);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL fixed_valid got %0b want 1", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_rr_all();
    logic [SW-1:0] exp_ch;
    logic [W-1:0]  exp_d;
    mode     = 1'b1;
    in_valid = 8'hFF;
    #1;
    total_cnt++;
    if (in_ready !== 8'h01) $display("FAIL rr_first_ready got %b want 00000001", in_ready);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_ch = SW'(i % N_CH);
      exp_d  = 8'(160 + (i % N_CH));
      total_cnt++;
      if (out_ch !== exp_ch || out_data !== exp_d || out_valid !== 1'b1)
        $display("FAIL rr_seq[%0d] got ch %0d data %h v %0b want ch %0d data %h v 1",
                 i, out_ch, out_data, out_valid, exp_ch, exp_d);
      else pass_cnt++;
    end
  endtask

  task automatic test_rr_skip();
    // Single grant on ch2 moves the pointer to 3.
    in_valid = 8'b0000_0100;
    tick();
    total_cnt++;
    if (out_ch !== 3'd2) $display("FAIL skip_setup got %0d want 2", out_ch);
    else pass_cnt++;
    in_valid = 8'b1000_0100;
    #1;
    total_cnt++;
    if (in_ready !== 8'b1000_0000) $display("FAIL skip_ready got %b want 10000000", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_ch !== 3'd7) $display("FAIL skip_g0 got %0d want 7", out_ch);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_ch !== 3'd2) $display("FAIL skip_g1 got %0d want 2", out_ch);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_ch !== 3'd7 || out_data !== 8'hA7)
      $display("FAIL skip_g2 got ch %0d data %h want ch 7 data a7", out_ch, out_data);
    else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    in_valid  = 8'hFF;
    out_ready = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 8'h00) $display("FAIL bp_ready0 got %b want 0", in_ready);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (out_data !== 8'hA7 || out_ch !== 3'd7 || out_valid !== 1'b1 || in_ready !== 8'h00)
        $display("FAIL bp_hold[%0d] got data %h ch %0d v %0b rdy %b want a7 7 1 0",
                 i, out_data, out_ch, out_valid, in_ready);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 8'h01) $display("FAIL bp_release_ready got %b want 00000001", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_data !== 8'hA0 || out_ch !== 3'd0 || out_valid !== 1'b1)
      $display("FAIL bp_reload got data %h ch %0d v %0b want a0 0 1",
               out_data, out_ch, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_fixed_invalid();
    mode     = 1'b0;
    sel      = 3'd4;
    in_valid = 8'b1110_1111;
    #1;
    total_cnt++;
    if (in_ready !== 8'h00) $display("FAIL inv_ready got %b want 0", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 8'hA0 || out_ch !== 3'd0)
      $display("FAIL inv_drain got v %0b data %h ch %0d want 0 a0 0",
               out_valid, out_data, out_ch);
    else pass_cnt++;
    // Pointer was 1 before the fixed-mode cycle and must still be 1.
    mode     = 1'b1;
    in_valid = 8'hFF;
    #1;
    total_cnt++;
    if (in_ready !== 8'h02) $display("FAIL inv_ptr_ready got %b want 00000010", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_ch !== 3'd1 || out_data !== 8'hA1)
      $display("FAIL inv_ptr_grant got ch %0d data %h want 1 a1", out_ch, out_data);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    tick();
    tick();
    tick();
    total_cnt++;
    if (out_ch !== 3'd4) $display("FAIL ar_pre got %0d want 4", out_ch);
    else pass_cnt++;
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 3'd0)
      $display("FAIL ar_clear got v %0b data %h ch %0d want 0 00 0",
               out_valid, out_data, out_ch);
    else pass_cnt++;
    #2;
    in_valid = 8'b0011_0000;
    rst_n    = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 8'b0001_0000) $display("FAIL ar_ready got %b want 00010000", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_ch !== 3'd4 || out_data !== 8'hA4 || out_valid !== 1'b1)
      $display("FAIL ar_first got ch %0d data %h v %0b want 4 a4 1",
               out_ch, out_data, out_valid);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    in_data   = '0;
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_skip();
    test_back_pressure();
    test_fixed_invalid();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
